// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: register word offsets and CTRL bit positions for perf_counter_ctrl
package perf_counter_pkg;
    localparam int MaxCounters = 32;
    localparam logic [7:0] reg_ctrl      = 8'h00;
    localparam logic [7:0] reg_mask      = 8'h01;
    localparam logic [7:0] reg_ovf       = 8'h02;
    localparam logic [7:0] reg_ovf_ie    = 8'h03;
    localparam logic [7:0] reg_limit_lo  = 8'h04;
    localparam logic [7:0] reg_limit_hi  = 8'h05;
    localparam logic [7:0] reg_snap_base = 8'h40;
    typedef enum logic [1:0] {
        ctrl_en   = 2'd0,
        ctrl_snap = 2'd1,
        ctrl_clr  = 2'd2
    } ctrl_bit_e;
endpackage

// File: rtl/perf_counter_slice.sv
// perf_counter_slice: one event counter with snapshot register and wrap detect
module perf_counter_slice #(
    parameter int CounterWidth = 40
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    snap,
    output logic [CounterWidth-1:0] count_nx,
    output logic [CounterWidth-1:0] snapshot,
    output logic                    wrap
);
    logic [CounterWidth-1:0] count;
    // clear wins over a same-cycle increment, so no wrap is reported then
    always_comb count_nx = clr ? '0 : count + CounterWidth'(inc);
    assign wrap = inc & ~clr & (&count);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count    <= '0;
            snapshot <= '0;
        end else begin
            count    <= count_nx;
            snapshot <= snap ? count : snapshot;
        end
    end
endmodule

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: bus-mapped bank of event counters with snapshot, overflow and limit stop
module perf_counter_ctrl
    import perf_counter_pkg::*;
#(
    parameter int NumCounters  = 8,
    parameter int CounterWidth = 40,
    parameter int LimitIdx     = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    input  logic [NumCounters-1:0] event_i,
    output logic                   limit_o,
    output logic                   irq_o
);
    logic [7:0] word;
    logic wr, snap, clr, lim_wr, hit, en;
    logic [NumCounters-1:0] mask, ovf, ovf_ie, inc, wrap, mask_nx, ovf_nx, ie_nx;
    logic [NumCounters-1:0][CounterWidth-1:0] count_nx, snapshot;
    logic [CounterWidth-1:0] limit, lim_nx;
    logic [31:0] rd_mux;
    assign word   = addr_i[9:2];
    assign wr     = req_i & we_i;
    assign snap   = wr & (word == reg_ctrl) & be_i[0] & wdata_i[ctrl_snap];
    assign clr    = wr & (word == reg_ctrl) & be_i[0] & wdata_i[ctrl_clr];
    assign lim_wr = wr & ((word == reg_limit_lo) | (word == reg_limit_hi));
    assign inc    = {NumCounters{en}} & mask & event_i;
    assign irq_o  = |(ovf & ovf_ie);
    assign hit    = (|limit) & inc[LimitIdx] & (count_nx[LimitIdx] == limit);
    for (genvar i = 0; i < NumCounters; i++) begin : g_slice
        perf_counter_slice #(.CounterWidth(CounterWidth)) u_slice (
            .clk_i(clk_i), .rst_ni(rst_ni), .inc(inc[i]), .clr(clr), .snap(snap),
            .count_nx(count_nx[i]), .snapshot(snapshot[i]), .wrap(wrap[i])
        );
    end
    always_comb begin
        mask_nx = mask;
        ie_nx   = ovf_ie;
        ovf_nx  = ovf | wrap;
        lim_nx  = limit;
        for (int i = 0; i < NumCounters; i++) begin
            if (wr && be_i[i/8]) begin
                mask_nx[i] = (word == reg_mask) ? wdata_i[i] : mask_nx[i];
                ie_nx[i]   = (word == reg_ovf_ie) ? wdata_i[i] : ie_nx[i];
                ovf_nx[i]  = (word == reg_ovf && wdata_i[i]) ? wrap[i] : ovf_nx[i];
            end
        end
        for (int j = 0; j < CounterWidth; j++)
            if (wr && be_i[(j%32)/8] && word == ((j < 32) ? reg_limit_lo : reg_limit_hi))
                lim_nx[j] = wdata_i[j%32];
    end
    always_comb begin
        rd_mux = '0;
        if (word == reg_ctrl)     rd_mux = {31'b0, en};
        if (word == reg_mask)     rd_mux = 32'(mask);
        if (word == reg_ovf)      rd_mux = 32'(ovf);
        if (word == reg_ovf_ie)   rd_mux = 32'(ovf_ie);
        if (word == reg_limit_lo) rd_mux = limit[31:0];
        if (word == reg_limit_hi) rd_mux = 32'(limit[CounterWidth-1:32]);
        for (int i = 0; i < NumCounters; i++) begin
            if (word == reg_snap_base + 8'(2*i))     rd_mux = snapshot[i][31:0];
            if (word == reg_snap_base + 8'(2*i + 1)) rd_mux = 32'(snapshot[i][CounterWidth-1:32]);
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en       <= 1'b0;
            mask     <= '0;
            ovf      <= '0;
            ovf_ie   <= '0;
            limit    <= '0;
            limit_o  <= 1'b0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            en       <= (wr && word == reg_ctrl && be_i[0]) ? wdata_i[ctrl_en] : en;
            mask     <= mask_nx;
            ovf      <= ovf_nx;
            ovf_ie   <= ie_nx;
            limit    <= lim_nx;
            limit_o  <= lim_wr ? 1'b0 : (limit_o | hit);
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd_mux : '0;
        end
    end
endmodule
